// File: rtl/tx_polyphase_filter_if.sv
// Bundles the sample, coefficient-load and output signals of tx_polyphase_filter.
// Ports (master drives the i_* side, slave drives the o_* side):
//   i_enable      advance one phase and produce one output sample
//   i_valid       a new baud bit is present on i_bits
//   i_bits        one bit per channel, 0 -> +1, 1 -> -1
//   i_coeff_we    coefficient write strobe
//   i_coeff_addr  coefficient address, phase*NBAUDS+tap
//   i_coeff_data  coefficient value, signed NB bits
//   o_data        filtered samples, channel c in [c*NB +: NB]
//   o_valid       o_data holds a new sample this cycle
//   o_sat         per-channel saturation flag of the current sample
//   o_phase       phase index of the sample on o_data
//   o_baud_req    the next enabled cycle is phase 0
interface tx_polyphase_filter_if #(
  parameter int NB     = 8,
  parameter int OS     = 4,
  parameter int NBAUDS = 6,
  parameter int NCH    = 2
);
  localparam int AW = $clog2(OS * NBAUDS);
  localparam int PW = $clog2(OS);

  logic              i_enable;
  logic              i_valid;
  logic [NCH-1:0]    i_bits;
  logic              i_coeff_we;
  logic [AW-1:0]     i_coeff_addr;
  logic [NB-1:0]     i_coeff_data;
  logic [NCH*NB-1:0] o_data;
  logic              o_valid;
  logic [NCH-1:0]    o_sat;
  logic [PW-1:0]     o_phase;
  logic              o_baud_req;

  modport master (
    output i_enable, i_valid, i_bits, i_coeff_we, i_coeff_addr, i_coeff_data,
    input  o_data, o_valid, o_sat, o_phase, o_baud_req
  );

  modport slave (
    input  i_enable, i_valid, i_bits, i_coeff_we, i_coeff_addr, i_coeff_data,
    output o_data, o_valid, o_sat, o_phase, o_baud_req
  );
endinterface

// File: rtl/tx_polyphase_filter.sv
// Polyphase pulse-shaping filter for binary baud streams.
// Each channel keeps an NBAUDS-bit history of antipodal symbols; every enabled
// cycle one phase of the shared coefficient set is applied to that history and
// the saturated sum is registered on the output.
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-low; clears state and all coefficients
//   bus    tx_polyphase_filter_if slave (inputs i_*, registered outputs o_*)
module tx_polyphase_filter #(
  parameter int NB     = 8,
  parameter int NBF    = 7,
  parameter int OS     = 4,
  parameter int NBAUDS = 6,
  parameter int NCH    = 2
) (
  input logic                  clock,
  input logic                  reset,
  tx_polyphase_filter_if.slave bus
);
  localparam int NCOEF = OS * NBAUDS;
  localparam int AW    = $clog2(NCOEF);
  localparam int PW    = $clog2(OS);
  // Accumulator wide enough for NBAUDS terms including negated -2^(NB-1).
  localparam int SW    = NB + $clog2(NBAUDS) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (NB - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Output fraction equals coefficient fraction, so NBF only constrains legality.
  if (NBF >= NB || OS < 2 || (OS & (OS - 1)) != 0 || NBAUDS < 2) begin : g_param_check
    $error("tx_polyphase_filter: illegal parameter set");
  end

  logic [PW-1:0]        phase_q, phase_d;
  logic [NBAUDS-1:0]    sr_q [NCH];
  logic [NBAUDS-1:0]    sr_d [NCH];
  logic signed [NB-1:0] coeff_q [NCOEF];
  logic signed [NB-1:0] coeff_d [NCOEF];
  logic [NCH*NB-1:0]    data_q, data_d;
  logic [NCH-1:0]       sat_q, sat_d;
  logic                 valid_q, valid_d;
  logic [PW-1:0]        ophase_q, ophase_d;
  logic                 breq_q, breq_d;

  logic                 accept;
  logic [NBAUDS-1:0]    taps [NCH];
  logic signed [SW-1:0] acc [NCH];
  logic signed [SW-1:0] cv;

  always_comb begin
    accept = bus.i_enable && bus.i_valid && (phase_q == '0);

    coeff_d = coeff_q;
    for (int i = 0; i < NCOEF; i++) begin
      if (bus.i_coeff_we && bus.i_coeff_addr == AW'(i)) begin
        coeff_d[i] = bus.i_coeff_data;
      end
    end

    // Taps are post-shift so an accepted bit contributes in its own cycle.
    // Coefficients come from coeff_q, so a write lands one cycle later.
    cv = '0;
    for (int c = 0; c < NCH; c++) begin
      taps[c] = accept ? {sr_q[c][NBAUDS-2:0], bus.i_bits[c]} : sr_q[c];
      acc[c]  = '0;
      for (int p = 0; p < OS; p++) begin
        if (phase_q == PW'(p)) begin
          for (int k = 0; k < NBAUDS; k++) begin
            cv = {{(SW - NB){coeff_q[p*NBAUDS+k][NB-1]}}, coeff_q[p*NBAUDS+k]};
            acc[c] = taps[c][k] ? (acc[c] - cv) : (acc[c] + cv);
          end
        end
      end
    end

    phase_d  = phase_q;
    sr_d     = sr_q;
    data_d   = data_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    ophase_d = ophase_q;
    breq_d   = breq_q;

    if (bus.i_enable) begin
      phase_d  = (phase_q == PW'(OS - 1)) ? '0 : phase_q + PW'(1);
      sr_d     = taps;
      valid_d  = 1'b1;
      ophase_d = phase_q;
      breq_d   = (phase_q == PW'(OS - 1));
      for (int c = 0; c < NCH; c++) begin
        if (acc[c] > SAT_MAX) begin
          data_d[c*NB +: NB] = SAT_MAX[NB-1:0];
          sat_d[c]           = 1'b1;
        end else if (acc[c] < SAT_MIN) begin
          data_d[c*NB +: NB] = SAT_MIN[NB-1:0];
          sat_d[c]           = 1'b1;
        end else begin
          data_d[c*NB +: NB] = acc[c][NB-1:0];
          sat_d[c]           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      for (int c = 0; c < NCH; c++) sr_q[c] <= '0;
      for (int i = 0; i < NCOEF; i++) coeff_q[i] <= '0;
      data_q   <= '0;
      sat_q    <= '0;
      valid_q  <= 1'b0;
      ophase_q <= '0;
      breq_q   <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      sr_q     <= sr_d;
      coeff_q  <= coeff_d;
      data_q   <= data_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      ophase_q <= ophase_d;
      breq_q   <= breq_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_sat      = sat_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_phase    = ophase_q;
  assign bus.o_baud_req = breq_q;
endmodule

// File: doc/tx_polyphase_filter.md
TX_POLYPHASE_FILTER -- requirements
Module: tx_polyphase_filter

Interface
REQ-001 Parameter NB, default 8: coefficient and output width, signed two's complement.
REQ-002 Parameter NBF, default 7: fractional bits of coefficients and outputs.
REQ-003 Parameter OS, default 4: oversampling factor (phases per baud), power of two, >= 2.
REQ-004 Parameter NBAUDS, default 6: taps per phase (baud span), >= 2.
REQ-005 Parameter NCH, default 2: independent channels (e.g. I/Q) sharing one coefficient set.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 i_enable  input  1  advances the phase counter and produces one output sample per cycle.
REQ-009 i_valid  input  1  a new baud bit is present on i_bits.
REQ-010 i_bits  input  NCH  one bit per channel; bit 0 maps to +1 and bit 1 maps to -1.
REQ-011 i_coeff_we  input  1  coefficient write strobe.
REQ-012 i_coeff_addr  input  clog2(OS*NBAUDS)  coefficient address, phase*NBAUDS+tap.
REQ-013 i_coeff_data  input  NB  coefficient value, S(NB,NBF).
REQ-014 o_data  output  NCH*NB  filtered samples, channel c in bits [c*NB +: NB].
REQ-015 o_valid  output  1  o_data holds a new sample this cycle.
REQ-016 o_sat  output  NCH  per-channel saturation flag for the current o_data sample.
REQ-017 o_phase  output  clog2(OS)  phase index of the sample on o_data.
REQ-018 o_baud_req  output  1  registered; high when the next enabled cycle is phase 0 (bit accepted there).

Function
REQ-019 The phase counter shall increment on every cycle with i_enable=1 and wrap OS-1 -> 0; it shall hold when i_enable=0.
REQ-020 A bit shall be accepted only when i_enable=1, i_valid=1 and phase=0; i_valid at any other phase or with i_enable=0 shall be ignored.
REQ-021 Each channel shall hold an NBAUDS-bit shift register; on acceptance, tap 0 takes the new bit and tap k takes the old tap k-1.
REQ-022 Taps used in a cycle shall be the post-shift values (accepted bit visible at tap 0 in the same cycle).
REQ-023 Coefficient RAM of OS*NBAUDS entries shall be written on i_coeff_we; addresses >= OS*NBAUDS shall be ignored.
REQ-024 A coefficient written in cycle n shall be used from cycle n+1; writes are legal while i_enable=1.
REQ-025 Per channel, the sum over taps k of (tap_k ? -coeff[phase][k] : +coeff[phase][k]) shall be computed at NB+clog2(NBAUDS)+1 bits, so negation of -2^(NB-1) cannot overflow.
REQ-026 The sum shall keep NBF fractional bits; if it lies in the signed NB-bit range, o_data shall be its low NB bits, otherwise o_data saturates to 2^(NB-1)-1 or -2^(NB-1) and o_sat is 1.
REQ-027 o_data, o_sat and o_phase shall be registered; a sample computed in enabled cycle n shall appear in cycle n+1 with o_valid=1 (latency 1).
REQ-028 When i_enable=0, o_valid shall be 0 on the following cycle and o_data, o_sat and o_phase shall hold.
REQ-029 o_baud_req shall be 1 when i_enable=1 and the phase is OS-1, or after reset before the first enabled cycle.

Reset
REQ-030 Reset low shall asynchronously clear the phase to 0, every shift register to 0, o_data to 0, o_sat to 0, o_valid to 0, o_phase to 0 and o_baud_req to 1.
REQ-031 Reset shall clear all coefficients to 0, and the block shall resume at phase 0 on the first enabled cycle after release, including when reset is asserted mid-baud.

Verification (NB=8, NBF=7, OS=4, NBAUDS=6, NCH=2)
REQ-032 Stimulus: assert reset during phase 2 with nonzero data. Response: all outputs reach their reset values immediately, and after release the first o_valid sample has o_phase=0.
REQ-033 Stimulus: coeff[0][0]=0x40 and all others 0; accept i_bits=2'b10 at phase 0. Response: next cycle ch0=0x40, ch1=0xC0, o_sat=0, o_phase=0; phases 1-3 output 0.
REQ-034 Stimulus: all 24 coefficients 0x7F; bits 00 held for 6 bauds, then 11 held for 6 bauds. Response: o_data=0x7F/0x7F with o_sat=11, then 0x80/0x80 with o_sat=11.
REQ-035 Stimulus: i_valid=1 with i_bits=11 at phases 1-3 only. Response: shift registers stay 0 and outputs match the all-zero-bit case.
REQ-036 Stimulus: i_enable low for 3 cycles at phase 2. Response: o_valid=0 and o_data held, then the sequence resumes at phase 3.
REQ-037 Stimulus: write 0x7F to address 24, and write coeff[1][2]=0x80 while i_enable=1. Response: the address-24 write has no effect, and the new coefficient is used from the next cycle (bit 1 on that tap gives +1.0, which saturates to 0x7F).
